// File: rtl/iob_dma_mc_pkg.sv
// Shared types and constants for the multi-channel DMA transfer controller.
// The optional interrupt output is enabled with IOB_DMA_MC_IRQ_EN.
package iob_dma_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } mc_state_e;

    localparam logic DIR_MEM2S = 1'b0;
    localparam logic DIR_S2MEM = 1'b1;

    // Channel index width, never narrower than one bit
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned N_CHAN_DFLT = 4;
    localparam int unsigned CHAN_IDX_W  = chan_idx_w(N_CHAN_DFLT);

endpackage

// File: rtl/iob_dma_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around the request vector.
module iob_dma_rr_arb
    import iob_dma_mc_pkg::*;
#(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = chan_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/iob_dma_mc_ctrl.sv
// Multi-channel DMA transfer controller: splits per-channel requests into
// segments and issues them round-robin to one shared engine. Optional
// interrupt output compiled in with IOB_DMA_MC_IRQ_EN.
module iob_dma_mc_ctrl
    import iob_dma_mc_pkg::*;
#(
    parameter int unsigned  N_CHAN = 4,
    parameter int unsigned  ADDR_W = 32,
    parameter int unsigned  DATA_W = 32,
    parameter int unsigned  LEN_W  = 24,
    parameter int unsigned  SEG_W  = 8,
    localparam int unsigned CIW    = chan_idx_w(N_CHAN)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              cfg_wen_i,
    input  logic [CIW-1:0]    cfg_chan_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              cfg_dir_i,
    output logic              cfg_err_o,
    output logic [N_CHAN-1:0] chan_busy_o,
    output logic [N_CHAN-1:0] chan_done_o,
    input  logic [N_CHAN-1:0] done_clr_i,
    output logic [ADDR_W-1:0] seg_addr_o,
    output logic [SEG_W-1:0]  seg_len_o,
    output logic              seg_dir_o,
    output logic              seg_valid_o,
    input  logic              seg_ready_i,
    input  logic              seg_done_i,
`ifdef IOB_DMA_MC_IRQ_EN
    input  logic [N_CHAN-1:0] irq_mask_i,
    output logic              irq_o,
`endif
    output logic [CIW-1:0]    sel_o
);

    localparam int unsigned      STRIDE  = DATA_W / 8;
    localparam logic [SEG_W-1:0] SEG_MAX = '1;

    mc_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q [N_CHAN];
    logic [LEN_W-1:0]  rem_q  [N_CHAN];
    logic [N_CHAN-1:0] dir_q;
    logic [N_CHAN-1:0] busy_q, busy_d;
    logic [N_CHAN-1:0] done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic [CIW-1:0]    ptr_q;
    logic [CIW-1:0]    sel_q;
    logic [ADDR_W-1:0] seg_addr_q;
    logic [SEG_W-1:0]  seg_len_q;
    logic              seg_dir_q;
    logic              seg_valid_q;

    logic              cfg_in_range;
    logic              cfg_load;
    logic              arb_load;
    logic              seg_fin;
    logic [LEN_W-1:0]  rem_after;

    logic [N_CHAN-1:0] arb_gnt;
    logic [CIW-1:0]    arb_idx;
    logic [ADDR_W-1:0] arb_addr;
    logic [LEN_W-1:0]  arb_rem;
    logic              arb_dir;
    logic [SEG_W-1:0]  arb_seg;

    iob_dma_rr_arb #(
        .N (N_CHAN)
    ) u_arb (
        .req     (busy_q),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // One-hot mux of the granted channel's context
    always_comb begin
        arb_addr = '0;
        arb_rem  = '0;
        arb_dir  = 1'b0;
        for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (arb_gnt[i]) begin
                arb_addr = arb_addr | addr_q[i];
                arb_rem  = arb_rem | rem_q[i];
                arb_dir  = arb_dir | dir_q[i];
            end
        end
    end

    assign arb_seg      = (arb_rem > LEN_W'(SEG_MAX)) ? SEG_MAX : SEG_W'(arb_rem);
    assign cfg_in_range = (32'(cfg_chan_i) < N_CHAN);
    assign seg_fin      = (state_q == ST_WAIT) && seg_done_i;
    assign rem_after    = rem_q[sel_q] - LEN_W'(seg_len_q);

    // Channel bookkeeping; busy is sampled pre-update so a write racing a completion is rejected
    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q & ~done_clr_i;
        cfg_err_d = 1'b0;
        cfg_load  = 1'b0;
        if (seg_fin && (rem_after == '0)) begin
            busy_d[sel_q] = 1'b0;
            done_d[sel_q] = 1'b1;
        end
        if (cfg_wen_i) begin
            if (!cfg_in_range || busy_q[cfg_chan_i]) begin
                cfg_err_d = 1'b1;
            end else if (cfg_len_i == '0) begin
                done_d[cfg_chan_i] = 1'b1;
            end else begin
                busy_d[cfg_chan_i] = 1'b1;
                cfg_load           = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        arb_load = 1'b0;
        case (state_q)
            ST_IDLE:  if (|busy_q) state_d = ST_ARB;
            ST_ARB: begin
                arb_load = 1'b1;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: if (seg_ready_i) state_d = ST_WAIT;
            ST_WAIT:  if (seg_done_i) state_d = (|busy_d) ? ST_ARB : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
            end
            dir_q       <= {N_CHAN{DIR_MEM2S}};
            busy_q      <= '0;
            done_q      <= '0;
            cfg_err_q   <= 1'b0;
            ptr_q       <= '0;
            sel_q       <= '0;
            seg_addr_q  <= '0;
            seg_len_q   <= '0;
            seg_dir_q   <= DIR_MEM2S;
            seg_valid_q <= 1'b0;
        end else if (cke_i) begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            seg_valid_q <= (state_d == ST_ISSUE);
            if (arb_load) begin
                sel_q      <= arb_idx;
                seg_addr_q <= arb_addr;
                seg_len_q  <= arb_seg;
                seg_dir_q  <= arb_dir;
            end
            // Address advance wraps modulo 2**ADDR_W by construction
            if (seg_fin) begin
                rem_q[sel_q]  <= rem_after;
                addr_q[sel_q] <= addr_q[sel_q] + ADDR_W'(seg_len_q) * ADDR_W'(STRIDE);
                ptr_q         <= (32'(sel_q) == N_CHAN - 1) ? '0 : sel_q + CIW'(1);
            end
            if (cfg_load) begin
                addr_q[cfg_chan_i] <= cfg_addr_i;
                rem_q[cfg_chan_i]  <= cfg_len_i;
                dir_q[cfg_chan_i]  <= cfg_dir_i;
            end
        end
    end

`ifdef IOB_DMA_MC_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            irq_q <= 1'b0;
        end else if (cke_i) begin
            irq_q <= |(done_q & irq_mask_i);
        end
    end

    assign irq_o = irq_q;
`endif

    assign cfg_err_o   = cfg_err_q;
    assign chan_busy_o = busy_q;
    assign chan_done_o = done_q;
    assign seg_addr_o  = seg_addr_q;
    assign seg_len_o   = seg_len_q;
    assign seg_dir_o   = seg_dir_q;
    assign seg_valid_o = seg_valid_q;
    assign sel_o       = sel_q;

endmodule

// File: tb/tb_iob_dma_mc_ctrl.sv
// Bench for iob_dma_mc_ctrl: directed scenarios plus randomized rounds,
// checked against a per-channel transfer model.
module tb_iob_dma_mc_ctrl;
    import iob_dma_mc_pkg::*;

    localparam int unsigned N_CHAN  = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LEN_W   = 24;
    localparam int unsigned SEG_W   = 8;
    localparam int          SEG_MAX = 255;
    localparam int          STRIDE  = 4;

    logic              clk_i = 1'b0;
    logic              cke_i;
    logic              arst_i;
    logic              cfg_wen_i;
    logic [1:0]        cfg_chan_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [LEN_W-1:0]  cfg_len_i;
    logic              cfg_dir_i;
    logic              cfg_err_o;
    logic [N_CHAN-1:0] chan_busy_o;
    logic [N_CHAN-1:0] chan_done_o;
    logic [N_CHAN-1:0] done_clr_i;
    logic [ADDR_W-1:0] seg_addr_o;
    logic [SEG_W-1:0]  seg_len_o;
    logic              seg_dir_o;
    logic              seg_valid_o;
    logic              seg_ready_i;
    logic              seg_done_i;
    logic [1:0]        sel_o;
`ifdef IOB_DMA_MC_IRQ_EN
    logic [N_CHAN-1:0] irq_mask_i;
    logic              irq_o;
`endif

    iob_dma_mc_ctrl dut (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .arst_i      (arst_i),
        .cfg_wen_i   (cfg_wen_i),
        .cfg_chan_i  (cfg_chan_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_dir_i   (cfg_dir_i),
        .cfg_err_o   (cfg_err_o),
        .chan_busy_o (chan_busy_o),
        .chan_done_o (chan_done_o),
        .done_clr_i  (done_clr_i),
        .seg_addr_o  (seg_addr_o),
        .seg_len_o   (seg_len_o),
        .seg_dir_o   (seg_dir_o),
        .seg_valid_o (seg_valid_o),
        .seg_ready_i (seg_ready_i),
        .seg_done_i  (seg_done_i),
`ifdef IOB_DMA_MC_IRQ_EN
        .irq_mask_i  (irq_mask_i),
        .irq_o       (irq_o),
`endif
        .sel_o       (sel_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: per-channel remaining words, next address, direction, flags
    logic [31:0] m_addr [N_CHAN];
    int          m_rem  [N_CHAN];
    bit          m_dir  [N_CHAN];
    bit          m_busy [N_CHAN];
    bit          m_done [N_CHAN];
    int          m_ptr;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] busy_vec();
        logic [3:0] v;
        for (int i = 0; i < N_CHAN; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [3:0] done_vec();
        logic [3:0] v;
        for (int i = 0; i < N_CHAN; i++) v[i] = m_done[i];
        return v;
    endfunction

    function automatic int m_pick();
        int c;
        for (int k = 0; k < N_CHAN; k++) begin
            c = (m_ptr + k) % N_CHAN;
            if (m_busy[c]) return c;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N_CHAN; i++) begin
            m_addr[i] = '0;
            m_rem[i]  = 0;
            m_dir[i]  = 1'b0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] a, input int len, input bit d,
                             input logic [3:0] clr);
        bit exp_err;
        cfg_wen_i  = 1'b1;
        cfg_chan_i = 2'(ch);
        cfg_addr_i = a;
        cfg_len_i  = 24'(len);
        cfg_dir_i  = d;
        done_clr_i = clr;
        tick();
        cfg_wen_i  = 1'b0;
        done_clr_i = '0;
        for (int i = 0; i < N_CHAN; i++) if (clr[i]) m_done[i] = 1'b0;
        exp_err = m_busy[ch];
        if (!exp_err) begin
            if (len == 0) begin
                m_done[ch] = 1'b1;
            end else begin
                m_busy[ch] = 1'b1;
                m_addr[ch] = a;
                m_rem[ch]  = len;
                m_dir[ch]  = d;
            end
        end
        chk("cfg_err", cfg_err_o, exp_err);
        chk("cfg_busy", chan_busy_o, busy_vec());
        chk("cfg_done", chan_done_o, done_vec());
    endtask

    task automatic clear_done(input logic [3:0] clr);
        done_clr_i = clr;
        tick();
        done_clr_i = '0;
        for (int i = 0; i < N_CHAN; i++) if (clr[i]) m_done[i] = 1'b0;
        chk("done_clr", chan_done_o, done_vec());
    endtask

    // Acts as the engine for one segment and checks it against the model
    task automatic run_seg(input int rdly, input int ddly);
        int ch;
        int len;
        int n;
        n = 0;
        while (seg_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("seg_valid_wait", seg_valid_o, 1'b1);
        if (seg_valid_o !== 1'b1) return;
        chk("busy_at_issue", chan_busy_o, busy_vec());
        ch = m_pick();
        if (ch < 0) return;
        len = (m_rem[ch] > SEG_MAX) ? SEG_MAX : m_rem[ch];
        chk("seg_sel", sel_o, 64'(ch));
        chk("seg_addr", seg_addr_o, m_addr[ch]);
        chk("seg_len", seg_len_o, 64'(len));
        chk("seg_dir", seg_dir_o, m_dir[ch]);
        for (int s = 0; s < rdly; s++) begin
            seg_done_i = 1'($urandom_range(0, 1));
            tick();
            chk("stall_valid", seg_valid_o, 1'b1);
            chk("stall_addr", seg_addr_o, m_addr[ch]);
            chk("stall_len", seg_len_o, 64'(len));
        end
        seg_done_i  = 1'b0;
        seg_ready_i = 1'b1;
        tick();
        seg_ready_i = 1'b0;
        chk("valid_drop", seg_valid_o, 1'b0);
        for (int s = 0; s < ddly; s++) tick();
        chk("sel_hold", sel_o, 64'(ch));
        seg_done_i = 1'b1;
        tick();
        seg_done_i = 1'b0;
        m_rem[ch]  = m_rem[ch] - len;
        m_addr[ch] = m_addr[ch] + 32'(len * STRIDE);
        if (m_rem[ch] == 0) begin
            m_busy[ch] = 1'b0;
            m_done[ch] = 1'b1;
        end
        m_ptr = (ch + 1) % N_CHAN;
        chk("post_busy", chan_busy_o, busy_vec());
        chk("post_done", chan_done_o, done_vec());
    endtask

    function automatic bit any_busy();
        for (int i = 0; i < N_CHAN; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          guard;
        int          ch;
        logic [3:0]  mask;
        cke_i       = 1'b1;
        arst_i      = 1'b1;
        cfg_wen_i   = 1'b0;
        cfg_chan_i  = '0;
        cfg_addr_i  = '0;
        cfg_len_i   = '0;
        cfg_dir_i   = 1'b0;
        done_clr_i  = '0;
        seg_ready_i = 1'b0;
        seg_done_i  = 1'b0;
`ifdef IOB_DMA_MC_IRQ_EN
        irq_mask_i  = '1;
`endif
        m_reset();
        repeat (3) tick();
        chk("rst_valid", seg_valid_o, 1'b0);
        chk("rst_busy", chan_busy_o, 4'b0);
        chk("rst_done", chan_done_o, 4'b0);
        chk("rst_err", cfg_err_o, 1'b0);
        chk("rst_sel", sel_o, 2'b0);
        chk("rst_addr", seg_addr_o, 32'b0);
        chk("rst_len", seg_len_o, 8'b0);
        arst_i = 1'b0;
        tick();

        // Single segment with latency check
        cfg_write(0, 32'h1000, 5, DIR_S2MEM, 4'b0);
        chk("lat_busy_edge", seg_valid_o, 1'b0);
        tick();
        chk("lat_arb", seg_valid_o, 1'b0);
        tick();
        chk("lat_issue", seg_valid_o, 1'b1);
        run_seg(0, 0);

        // Split into three segments
        cfg_write(1, 32'h0, 600, DIR_MEM2S, 4'b0);
        for (int k = 0; k < 3; k++) run_seg(1, 2);

        // Zero length with a simultaneous clear (set wins), then a busy rewrite
        cfg_write(3, 32'hABC, 0, DIR_MEM2S, 4'b1000);
        repeat (4) tick();
        chk("len0_no_seg", seg_valid_o, 1'b0);
        cfg_write(0, 32'h2000, 3, DIR_MEM2S, 4'b0);
        cfg_write(0, 32'h9999, 7, DIR_S2MEM, 4'b0);
        tick();
        chk("err_pulse_end", cfg_err_o, 1'b0);
        clear_done(4'b1010);
        run_seg(0, 1);

        // Clock-enable freeze followed by long backpressure
        cfg_write(3, 32'h4000, 8, DIR_S2MEM, 4'b0);
        n = 0;
        while (seg_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cke_valid_before", seg_valid_o, 1'b1);
        cke_i       = 1'b0;
        seg_ready_i = 1'b1;
        seg_done_i  = 1'b1;
        repeat (3) tick();
        cke_i       = 1'b1;
        seg_ready_i = 1'b0;
        seg_done_i  = 1'b0;
        chk("cke_valid_held", seg_valid_o, 1'b1);
        chk("cke_busy_held", chan_busy_o, busy_vec());
        run_seg(10, 0);

        // Reset while the engine is working on a segment
        cfg_write(2, 32'h5000, 20, DIR_S2MEM, 4'b0);
        n = 0;
        while (seg_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        seg_ready_i = 1'b1;
        tick();
        seg_ready_i = 1'b0;
        tick();
        chk("pre_rst_sel", sel_o, 2'd2);
        arst_i = 1'b1;
        #1;
        chk("arst_valid", seg_valid_o, 1'b0);
        chk("arst_busy", chan_busy_o, 4'b0);
        chk("arst_done", chan_done_o, 4'b0);
        chk("arst_sel", sel_o, 2'b0);
        chk("arst_addr", seg_addr_o, 32'b0);
        chk("arst_len", seg_len_o, 8'b0);
        chk("arst_dir", seg_dir_o, 1'b0);
        tick();
        arst_i = 1'b0;
        m_reset();
        seg_done_i = 1'b1;
        tick();
        seg_done_i = 1'b0;
        repeat (5) tick();
        chk("post_rst_no_seg", seg_valid_o, 1'b0);
        chk("post_rst_done", chan_done_o, 4'b0);

        // Round-robin between two channels
        cfg_write(0, 32'h100, 300, DIR_MEM2S, 4'b0);
        cfg_write(2, 32'h8000, 10, DIR_S2MEM, 4'b0);
        for (int k = 0; k < 3; k++) run_seg(0, 1);

        // Address wrap
        cfg_write(0, 32'hFFFF_FFF8, 4, DIR_S2MEM, 4'b0);
        run_seg(0, 0);
        cfg_write(1, 32'hFFFF_FC00, 600, DIR_MEM2S, 4'b0);
        for (int k = 0; k < 3; k++) run_seg(0, 0);

        // Randomized rounds; channels armed in rotation order from the pointer
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N_CHAN; k++) begin
                ch = (m_ptr + k) % N_CHAN;
                if (mask[ch])
                    cfg_write(ch, $urandom(), ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 700)),
                              1'($urandom_range(0, 1)), 4'b0);
            end
            ch = m_pick();
            if (ch >= 0 && $urandom_range(0, 1) == 1)
                cfg_write(ch, $urandom(), int'($urandom_range(1, 50)), 1'b0, 4'b0);
            guard = 0;
            while (any_busy() && guard < 60) begin
                run_seg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                guard++;
            end
            chk("round_idle", chan_busy_o, 4'b0);
            clear_done(4'($urandom_range(0, 15)));
        end

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
